// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: controller FSM states and stage indices.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } ctrl_state_e;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int DEFAULT_NUM_STAGES = 6;

endpackage

// File: rtl/stall_prio_mask.sv
// Highest-set-bit to thermometer mask: every stage at or below the highest
// requesting stage is held, so younger stages never run into an older held one.
module stall_prio_mask #(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] req,
  output logic [NUM_STAGES-1:0] mask
);

  logic acc_s;

  // Running OR from the oldest stage downward.
  always_comb begin
    acc_s = 1'b0;
    mask  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      acc_s   = acc_s | req[k];
      mask[k] = acc_s;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: per-stage stall merge, counted multi-cycle
// stall and registered flush/redirect. Optional macro: STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int MC_STAGE   = STG_EX,
  parameter int CNT_W      = 6,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  mc_start,
  input  logic [CNT_W-1:0]      mc_cycles,
  input  logic                  flush_req,
  input  logic [PC_W-1:0]       flush_pc_in,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [PC_W-1:0]       flush_pc,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [31:0]           perf_stall_cnt
);

  ctrl_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PC_W-1:0]       flush_pc_q, flush_pc_d;
  logic                  start_ok_s;
  logic                  mc_active_s;
  logic [NUM_STAGES-1:0] req_s;
  logic [NUM_STAGES-1:0] mask_s;

  // A zero-length request is ignored; the start cycle itself already stalls.
  assign start_ok_s  = (state_q == IDLE) && mc_start && (mc_cycles != {CNT_W{1'b0}});
  assign mc_active_s = start_ok_s || (state_q == MC_BUSY);

  // Fold the multi-cycle stall into the request vector; bit 0 is never a requester.
  always_comb begin
    req_s    = stall_req;
    req_s[0] = 1'b0;
    if (mc_active_s) begin
      req_s[MC_STAGE] = 1'b1;
    end else begin
      req_s[MC_STAGE] = stall_req[MC_STAGE];
    end
  end

  stall_prio_mask #(.NUM_STAGES(NUM_STAGES)) u_mask (
    .req  (req_s),
    .mask (mask_s)
  );

  // Combinational outputs; counter value 1 in MC_BUSY marks the last stalled cycle.
  always_comb begin
    stall   = {NUM_STAGES{1'b0}};
    mc_done = 1'b0;
    if (rst && (state_q != FLUSH)) begin
      stall = mask_s;
    end else begin
      stall = {NUM_STAGES{1'b0}};
    end
    if (rst && !flush_req) begin
      if ((state_q == MC_BUSY) && (cnt_q == CNT_W'(1))) begin
        mc_done = 1'b1;
      end else if (start_ok_s && (mc_cycles == CNT_W'(1))) begin
        mc_done = 1'b1;
      end else begin
        mc_done = 1'b0;
      end
    end else begin
      mc_done = 1'b0;
    end
  end

  assign mc_busy  = (state_q == MC_BUSY);
  assign flush    = (state_q == FLUSH);
  assign flush_pc = flush_pc_q;

  // Next state: a flush request overrides everything and aborts a multi-cycle stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_pc_d = flush_pc_q;
    if (flush_req) begin
      state_d    = FLUSH;
      cnt_d      = {CNT_W{1'b0}};
      flush_pc_d = flush_pc_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok_s && (mc_cycles != CNT_W'(1))) begin
            state_d = MC_BUSY;
            cnt_d   = mc_cycles - CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        MC_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FLUSH:   state_d = IDLE;
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      flush_pc_q <= {PC_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_pc_q <= flush_pc_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    perf_d = perf_q;
    if (stall[0] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model predicts
// each cycle's outputs into a queue, and a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_req = 6'd0;
  logic        mc_start = 1'b0;
  logic [5:0]  mc_cycles = 6'd0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc_in = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        mc_busy;
  logic        mc_done;
  logic [31:0] perf_stall_cnt;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_pc_in(flush_pc_in),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .mc_busy(mc_busy),
    .mc_done(mc_done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    bit          chk_pc;
    logic        busy;
    logic        done;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: remaining busy cycles after the start cycle,
  // pending flush cycle, latched target, stalled-cycle count.
  int          m_rem = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_fpc = 32'd0;
  longint      m_perf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs, advance the model.
  task automatic cycle(input bit r, input logic [5:0] req, input bit ms,
                       input logic [5:0] mcc, input bit fr, input logic [31:0] fpc);
    exp_t e;
    int   h;
    bit   act;
    @(posedge clk);
    #1;
    rst = r; stall_req = req; mc_start = ms; mc_cycles = mcc;
    flush_req = fr; flush_pc_in = fpc;
    if (!r) begin
      m_rem = 0; m_flush = 1'b0; m_fpc = 32'd0; m_perf = 0;
      e = '{stall: 6'd0, flush: 1'b0, fpc: 32'd0, chk_pc: 1'b1,
            busy: 1'b0, done: 1'b0, perf: 32'd0};
    end else if (m_flush) begin
      e = '{stall: 6'd0, flush: 1'b1, fpc: m_fpc, chk_pc: 1'b1,
            busy: 1'b0, done: 1'b0, perf: 32'd0};
    end else begin
      act = (m_rem > 0) || (ms && mcc != 6'd0);
      h = -1;
      for (int k = 1; k < 6; k++) if (req[k]) h = k;
      if (act && h < 3) h = 3;
      e.stall  = 6'((1 << (h + 1)) - 1);
      e.flush  = 1'b0;
      e.fpc    = 32'd0;
      e.chk_pc = 1'b0;
      e.busy   = (m_rem > 0);
      e.done   = !fr && ((m_rem == 1) || (m_rem == 0 && ms && mcc == 6'd1));
      e.perf   = 32'd0;
    end
    if (r) begin
      if (fr) begin
        m_flush = 1'b1; m_fpc = fpc; m_rem = 0;
      end else if (m_flush) begin
        m_flush = 1'b0;
      end else if (m_rem > 0) begin
        m_rem--;
      end else if (ms && mcc != 6'd0) begin
        m_rem = int'(mcc) - 1;
      end
    end
`ifdef STALL_PERF_CNT_EN
    e.perf = 32'(m_perf);
    if (r && e.stall[0] && m_perf < 64'hFFFF_FFFF) m_perf++;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", 64'(stall), 64'(e.stall));
        chk("flush", 64'(flush), 64'(e.flush));
        chk("mc_busy", 64'(mc_busy), 64'(e.busy));
        chk("mc_done", 64'(mc_done), 64'(e.done));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(e.perf));
        if (e.chk_pc) chk("flush_pc", 64'(flush_pc), 64'(e.fpc));
      end
    end
  end

  // Protocol guard: mc_start must never be issued while a multi-cycle stall runs.
  always @(negedge clk) begin
    if (rst && mc_start && mc_busy) begin
      errors++;
      $display("FAIL protocol: mc_start while mc_busy at %0t", $time);
    end
  end

  initial begin
    bit          r, ms, fr;
    logic [5:0]  req, mcc;
    logic [31:0] fpc;
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'b111110, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'b111110, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'b000100, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'b001010, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'b000000, 1'b0, 6'd0, 1'b0, 32'd0);
    // Multi-cycle length 5, then length 0 and length 1.
    cycle(1'b1, 6'd0, 1'b1, 6'd5, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b1, 6'd1, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    // Flush aborting a length-10 stall on its third cycle.
    cycle(1'b1, 6'd0, 1'b1, 6'd10, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 32'h0000_0180);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    // Overlap of a multi-cycle stall with a MEM-stage request.
    cycle(1'b1, 6'd0, 1'b1, 6'd6, 1'b0, 32'd0);
    cycle(1'b1, 6'b010000, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'b010000, 1'b0, 6'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    // Back-to-back flush requests, then a mid-operation reset.
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 32'h0000_1000);
    cycle(1'b1, 6'b100000, 1'b1, 6'd3, 1'b1, 32'h0000_2000);
    cycle(1'b1, 6'b100000, 1'b1, 6'd3, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b1, 6'd7, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) != 0);
      req = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      fr  = ($urandom_range(0, 24) == 0);
      fpc = $urandom;
      ms  = (m_rem == 0) && ($urandom_range(0, 5) == 0);
      mcc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 4));
      cycle(r, req, ms, mcc, fr, fpc);
    end
    cycle(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
